maxpool_2x2_unit: RTL and testbench

- Downstream consumer of the dual row-stack buffer in the CCM register-array path.
- Each enabled beat takes one column pixel from two vertically adjacent feature-map rows (top and bottom).
- Performs a 2x2, stride-2 unsigned max-pool and emits one pooled pixel per column pair, with an output column index and an end-of-row pulse.
- Row width comes from the same runtime size control that drives the upstream stacks.

---
 rtl/maxpool_pkg.sv | 8 +
 rtl/maxpool_2x2_unit_pool_max2.sv | 14 +
 rtl/maxpool_2x2_unit.sv | 105 ++++++++++
 tb/tb_maxpool_2x2_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/maxpool_pkg.sv
// Shared sizing defaults for the 2x2 max-pool stage behind the dual row-stack buffer.
package maxpool_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_COL_W  = 9;
  localparam int DEF_SIZE_W = 8;
  // Pooling window edge; the datapath is currently hard-wired to 2x2.
  localparam int POOL_K     = 2;
endpackage

// File: rtl/maxpool_2x2_unit_pool_max2.sv
// Unsigned max of two pixels, purely combinational (zero latency, no flow control).
import maxpool_pkg::*;

module pool_max2 #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  assign y = (a >= b) ? a : b;

endmodule

// File: rtl/maxpool_2x2_unit.sv
// 2x2 stride-2 unsigned max-pool over a top/bottom row pair; one output per column pair.
// One register stage; en qualifies every beat and all state holds while it is low.
import maxpool_pkg::*;

module maxpool_2x2_unit #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COL_W  = DEF_COL_W,
  parameter int SIZE_W = DEF_SIZE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] row_top,
  input  logic [DATA_W-1:0] row_bot,
  input  logic [SIZE_W-1:0] SIZE_maxpooling_IN,
  output logic [DATA_W-1:0] pool_out,
  output logic              pool_valid,
  output logic [COL_W-1:0]  pool_col,
  output logic              row_done
);

  logic [COL_W-1:0]  in_col_q, in_col_d;
  logic [COL_W-1:0]  out_cnt_q, out_cnt_d;
  logic [COL_W-1:0]  pool_col_q, pool_col_d;
  logic              phase_q, phase_d;
  logic              pool_valid_q, pool_valid_d;
  logic              row_done_q, row_done_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] pool_out_q, pool_out_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [SIZE_W-1:0] eff;
  logic [DATA_W-1:0] vmax, hmax;
  logic              first_col, last;

  pool_max2 #(.DATA_W(DATA_W)) u_vmax (.a(row_top), .b(row_bot), .y(vmax));
  pool_max2 #(.DATA_W(DATA_W)) u_hmax (.a(hold_q),  .b(vmax),    .y(hmax));

  // Row width is sampled only on column 0 so a mid-row size change waits for the next row.
  assign first_col = (in_col_q == '0);
  assign eff       = first_col ? SIZE_maxpooling_IN : size_q;
  assign last      = en && ((eff < SIZE_W'(2)) || (in_col_q == COL_W'(eff - SIZE_W'(1))));

  always_comb begin
    in_col_d     = in_col_q;
    out_cnt_d    = out_cnt_q;
    pool_col_d   = pool_col_q;
    phase_d      = phase_q;
    hold_d       = hold_q;
    pool_out_d   = pool_out_q;
    size_d       = size_q;
    pool_valid_d = 1'b0;
    row_done_d   = 1'b0;
    if (en) begin
      if (first_col) size_d = SIZE_maxpooling_IN;
      if (!phase_q) begin
        hold_d  = vmax;
        phase_d = 1'b1;
      end else begin
        pool_out_d   = hmax;
        pool_valid_d = 1'b1;
        pool_col_d   = out_cnt_q;
        out_cnt_d    = out_cnt_q + COL_W'(1);
        phase_d      = 1'b0;
      end
      in_col_d = in_col_q + COL_W'(1);
      // An unpaired trailing column only touched hold and is dropped here.
      if (last) begin
        in_col_d   = '0;
        phase_d    = 1'b0;
        out_cnt_d  = '0;
        row_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_col_q     <= '0;
      out_cnt_q    <= '0;
      pool_col_q   <= '0;
      phase_q      <= 1'b0;
      hold_q       <= '0;
      pool_out_q   <= '0;
      size_q       <= '0;
      pool_valid_q <= 1'b0;
      row_done_q   <= 1'b0;
    end else begin
      in_col_q     <= in_col_d;
      out_cnt_q    <= out_cnt_d;
      pool_col_q   <= pool_col_d;
      phase_q      <= phase_d;
      hold_q       <= hold_d;
      pool_out_q   <= pool_out_d;
      size_q       <= size_d;
      pool_valid_q <= pool_valid_d;
      row_done_q   <= row_done_d;
    end
  end

  assign pool_out   = pool_out_q;
  assign pool_valid = pool_valid_q;
  assign pool_col   = pool_col_q;
  assign row_done   = row_done_q;

endmodule

// File: tb/tb_maxpool_2x2_unit.sv
// Bench for maxpool_2x2_unit: vector table plus reset-mid-row sequence, checked via a timed queue.
module tb_maxpool_2x2_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] row_top = '0;
  logic [7:0] row_bot = '0;
  logic [7:0] size_in = '0;
  logic [7:0] pool_out;
  logic       pool_valid;
  logic [8:0] pool_col;
  logic       row_done;

  maxpool_2x2_unit dut (
    .clk(clk), .rst(rst), .en(en), .row_top(row_top), .row_bot(row_bot),
    .SIZE_maxpooling_IN(size_in), .pool_out(pool_out), .pool_valid(pool_valid),
    .pool_col(pool_col), .row_done(row_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] top;
    logic [7:0] bot;
    logic [7:0] size;
    logic       ev;
    logic [7:0] eo;
    logic [8:0] ec;
    logic       ed;
    logic       chk;
  } vec_t;

  typedef struct {
    int         due;
    logic       ev;
    logic [7:0] eo;
    logic [8:0] ec;
    logic       ed;
    logic       chk;
  } exp_t;

  vec_t vecs[$];
  exp_t expq[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Apply one beat and record what the DUT must show one cycle later.
  task automatic beat(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    en      = v.en;
    row_top = v.top;
    row_bot = v.bot;
    size_in = v.size;
    e.due = cyc + 1;
    e.ev  = v.ev;
    e.eo  = v.eo;
    e.ec  = v.ec;
    e.ed  = v.ed;
    e.chk = v.chk;
    expq.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #4;
    while (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      check("pool_valid", int'(pool_valid), int'(e.ev));
      check("row_done", int'(row_done), int'(e.ed));
      if (e.chk) begin
        check("pool_out", int'(pool_out), int'(e.eo));
        check("pool_col", int'(pool_col), int'(e.ec));
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_pool_out"}, int'(pool_out), 0);
    check({tag, "_pool_valid"}, int'(pool_valid), 0);
    check({tag, "_pool_col"}, int'(pool_col), 0);
    check({tag, "_row_done"}, int'(row_done), 0);
  endtask

  initial begin
    // en top bot size | ev eo ec ed chk
    // SIZE=4 continuous
    vecs.push_back('{1, 8'd1,   8'd5, 8'd4, 0, 8'd0,   9'd0, 0, 1});
    vecs.push_back('{1, 8'd9,   8'd2, 8'd4, 1, 8'd9,   9'd0, 0, 1});
    vecs.push_back('{1, 8'd3,   8'd8, 8'd4, 0, 8'd9,   9'd0, 0, 1});
    vecs.push_back('{1, 8'd4,   8'd7, 8'd4, 1, 8'd8,   9'd1, 1, 1});
    // Same row with en low for 3 cycles between beats 1 and 2
    vecs.push_back('{1, 8'd1,   8'd5, 8'd4, 0, 8'd8,   9'd1, 0, 1});
    vecs.push_back('{0, 8'hAA,  8'h55, 8'd1, 0, 8'd8,  9'd1, 0, 1});
    vecs.push_back('{0, 8'hFF,  8'hFF, 8'd0, 0, 8'd8,  9'd1, 0, 1});
    vecs.push_back('{0, 8'h00,  8'hEE, 8'd2, 0, 8'd8,  9'd1, 0, 1});
    vecs.push_back('{1, 8'd9,   8'd2, 8'd4, 1, 8'd9,   9'd0, 0, 1});
    vecs.push_back('{1, 8'd3,   8'd8, 8'd4, 0, 8'd9,   9'd0, 0, 1});
    vecs.push_back('{1, 8'd4,   8'd7, 8'd4, 1, 8'd8,   9'd1, 1, 1});
    // SIZE=5: trailing column discarded
    vecs.push_back('{1, 8'd10,  8'd0, 8'd5, 0, 8'd8,   9'd1, 0, 1});
    vecs.push_back('{1, 8'd20,  8'd0, 8'd5, 1, 8'd20,  9'd0, 0, 1});
    vecs.push_back('{1, 8'd30,  8'd0, 8'd5, 0, 8'd20,  9'd0, 0, 1});
    vecs.push_back('{1, 8'd40,  8'd0, 8'd5, 1, 8'd40,  9'd1, 0, 1});
    vecs.push_back('{1, 8'd250, 8'd0, 8'd5, 0, 8'd40,  9'd1, 1, 1});
    // Next row restarts at column 0; 0xFF vs 0x00
    vecs.push_back('{1, 8'hFF,  8'h00, 8'd2, 0, 8'd40, 9'd1, 0, 1});
    vecs.push_back('{1, 8'h00,  8'h00, 8'd2, 1, 8'hFF, 9'd0, 1, 1});
    // SIZE 4 -> 2 at beat 2: this row still 4 beats, next row 2 beats
    vecs.push_back('{1, 8'd7,   8'd0, 8'd4, 0, 8'hFF,  9'd0, 0, 1});
    vecs.push_back('{1, 8'd1,   8'd0, 8'd2, 1, 8'd7,   9'd0, 0, 1});
    vecs.push_back('{1, 8'd2,   8'd0, 8'd2, 0, 8'd7,   9'd0, 0, 1});
    vecs.push_back('{1, 8'd3,   8'd0, 8'd2, 1, 8'd3,   9'd1, 1, 1});
    vecs.push_back('{1, 8'd4,   8'd5, 8'd2, 0, 8'd3,   9'd1, 0, 1});
    vecs.push_back('{1, 8'd6,   8'd0, 8'd2, 1, 8'd6,   9'd0, 1, 1});
    // SIZE=1 and SIZE=0: every beat is last, never a pool_valid
    for (int i = 0; i < 4; i++)
      vecs.push_back('{1, 8'h11 * 8'(i + 1), 8'hF0, 8'd1, 0, 8'd6, 9'd0, 1, 1});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{1, 8'h22 * 8'(i + 1), 8'h0F, 8'd0, 0, 8'd6, 9'd0, 1, 1});
    // Ties, then an unsigned-only ordering (0x80 > 0x7F)
    vecs.push_back('{1, 8'h80,  8'h80, 8'd2, 0, 8'd6,  9'd0, 0, 1});
    vecs.push_back('{1, 8'h80,  8'h80, 8'd2, 1, 8'h80, 9'd0, 1, 1});
    vecs.push_back('{1, 8'h7F,  8'h01, 8'd2, 0, 8'h80, 9'd0, 0, 1});
    vecs.push_back('{1, 8'h00,  8'h80, 8'd2, 1, 8'h80, 9'd0, 1, 1});
    vecs.push_back('{0, 8'h00,  8'h00, 8'd2, 0, 8'h80, 9'd0, 0, 1});

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    foreach (vecs[i]) beat(vecs[i]);

    // Reset after beat 3 of a SIZE=6 row, then a clean 6-beat row
    beat('{1, 8'd1, 8'd0, 8'd6, 0, 8'h80, 9'd0, 0, 1});
    beat('{1, 8'd2, 8'd0, 8'd6, 1, 8'd2,  9'd0, 0, 1});
    beat('{1, 8'd3, 8'd0, 8'd6, 0, 8'd2,  9'd0, 0, 1});
    beat('{0, 8'd0, 8'd0, 8'd6, 0, 8'd2,  9'd0, 0, 1});
    @(posedge clk);
    #5;
    rst = 1'b1;
    #1;
    check_zero("midrow_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    beat('{1, 8'd9, 8'd0, 8'd6, 0, 8'd0, 9'd0, 0, 1});
    beat('{1, 8'd1, 8'd0, 8'd6, 1, 8'd9, 9'd0, 0, 1});
    beat('{1, 8'd2, 8'd0, 8'd6, 0, 8'd9, 9'd0, 0, 1});
    beat('{1, 8'd8, 8'd0, 8'd6, 1, 8'd8, 9'd1, 0, 1});
    beat('{1, 8'd4, 8'd0, 8'd6, 0, 8'd8, 9'd1, 0, 1});
    beat('{1, 8'd4, 8'd0, 8'd6, 1, 8'd4, 9'd2, 1, 1});
    beat('{0, 8'd0, 8'd0, 8'd6, 0, 8'd4, 9'd2, 0, 1});

    repeat (3) @(posedge clk);
    #5;
    check("expect_queue_drained", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
